// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser with running status, channel-mask filtering, realtime and SysEx reporting.
// Optional Active Sensing timeout monitor is compiled in with `define AS_TIMEOUT_EN.
module midi_msg_parser #(
  parameter int unsigned CH_MASK_W   = 16,
  parameter int unsigned SYSEX_LEN_W = 8,
  parameter int unsigned AS_TIMEOUT  = 15000000,
  parameter int unsigned AS_CNT_W    = 24
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  input  logic [CH_MASK_W-1:0]   ch_mask,
  output logic                   msg_valid,
  output logic [3:0]             msg_type,
  output logic [3:0]             msg_ch,
  output logic [6:0]             msg_d0,
  output logic [6:0]             msg_d1,
  output logic                   rt_valid,
  output logic [7:0]             rt_byte,
  output logic                   sysex_active,
  output logic                   sysex_data_valid,
  output logic [SYSEX_LEN_W-1:0] sysex_len,
  output logic                   sysex_done,
  output logic                   as_timeout
);

  typedef enum logic [1:0] {StIdle, StWaitD0, StWaitD1, StSysex} state_e;

  state_e     state_q;
  logic [7:0] status_q;
  logic       rs_valid_q;
  logic [6:0] d0_q;

  logic       is_rt;
  logic       one_byte;
  logic       mask_hit;
  logic       complete;
  logic [6:0] cmp_d0;
  logic [6:0] cmp_d1;

  assign is_rt    = byte_in[7:3] == 5'b11111;
  // System common is never filtered by the channel mask.
  assign mask_hit = (status_q[7:4] == 4'hF) || ch_mask[status_q[3:0]];

  always_comb begin
    one_byte = (status_q[7:4] == 4'hC) || (status_q[7:4] == 4'hD) ||
               (status_q == 8'hF1) || (status_q == 8'hF3);
  end

  always_comb begin
    complete = 1'b0;
    cmp_d0   = d0_q;
    cmp_d1   = 7'd0;
    if (byte_valid && !byte_in[7]) begin
      if (state_q == StWaitD0 && one_byte) begin
        complete = 1'b1;
        cmp_d0   = byte_in[6:0];
      end else if (state_q == StWaitD1) begin
        complete = 1'b1;
        cmp_d1   = byte_in[6:0];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q          <= StIdle;
      status_q         <= 8'd0;
      rs_valid_q       <= 1'b0;
      d0_q             <= 7'd0;
      msg_valid        <= 1'b0;
      msg_type         <= 4'd0;
      msg_ch           <= 4'd0;
      msg_d0           <= 7'd0;
      msg_d1           <= 7'd0;
      rt_valid         <= 1'b0;
      rt_byte          <= 8'd0;
      sysex_active     <= 1'b0;
      sysex_data_valid <= 1'b0;
      sysex_len        <= '0;
      sysex_done       <= 1'b0;
    end else begin
      msg_valid        <= 1'b0;
      rt_valid         <= 1'b0;
      sysex_data_valid <= 1'b0;
      sysex_done       <= 1'b0;
      if (byte_valid) begin
        if (is_rt) begin
          rt_valid <= 1'b1;
          rt_byte  <= byte_in;
        end else if (byte_in[7]) begin
          // Any non-realtime status terminates an open SysEx.
          if (state_q == StSysex) begin
            sysex_done   <= 1'b1;
            sysex_active <= 1'b0;
          end
          d0_q <= 7'd0;
          if (byte_in[7:4] != 4'hF) begin
            status_q   <= byte_in;
            rs_valid_q <= 1'b1;
            state_q    <= StWaitD0;
          end else begin
            rs_valid_q <= 1'b0;
            case (byte_in[3:0])
              4'h0: begin
                state_q      <= StSysex;
                sysex_active <= 1'b1;
                sysex_len    <= '0;
              end
              4'h1, 4'h2, 4'h3: begin
                status_q <= byte_in;
                state_q  <= StWaitD0;
              end
              4'h6: begin
                msg_valid <= 1'b1;
                msg_type  <= 4'hF;
                msg_ch    <= 4'h6;
                msg_d0    <= 7'd0;
                msg_d1    <= 7'd0;
                state_q   <= StIdle;
              end
              default: state_q <= StIdle;
            endcase
          end
        end else begin
          case (state_q)
            StWaitD0: begin
              if (!one_byte) begin
                d0_q    <= byte_in[6:0];
                state_q <= StWaitD1;
              end
            end
            StSysex: begin
              sysex_data_valid <= 1'b1;
              if (sysex_len != '1) sysex_len <= sysex_len + 1'b1;
            end
            default: ;
          endcase
          if (complete) begin
            state_q <= rs_valid_q ? StWaitD0 : StIdle;
            d0_q    <= 7'd0;
            if (mask_hit) begin
              msg_valid <= 1'b1;
              msg_type  <= status_q[7:4];
              msg_ch    <= status_q[3:0];
              msg_d0    <= cmp_d0;
              msg_d1    <= cmp_d1;
            end
          end
        end
      end
    end
  end

`ifdef AS_TIMEOUT_EN
  localparam logic [AS_CNT_W-1:0] AsLimit = AS_CNT_W'(AS_TIMEOUT - 1);

  logic [AS_CNT_W-1:0] as_cnt_q;
  logic                as_armed_q;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      as_cnt_q   <= '0;
      as_armed_q <= 1'b0;
      as_timeout <= 1'b0;
    end else if (byte_valid) begin
      as_cnt_q <= '0;
      if (byte_in == 8'hFE) begin
        as_armed_q <= 1'b1;
        as_timeout <= 1'b0;
      end
    end else if (as_armed_q) begin
      if (as_cnt_q == AsLimit) begin
        as_timeout <= 1'b1;
        as_armed_q <= 1'b0;
      end else begin
        as_cnt_q <= as_cnt_q + 1'b1;
      end
    end
  end
`else
  assign as_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_midi_msg_parser.sv
// Directed testbench for midi_msg_parser: note, running status, realtime, SysEx, filtering,
// system common, reset and (when AS_TIMEOUT_EN is defined) the Active Sensing timeout.
module tb_midi_msg_parser;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic [15:0] ch_mask;
  logic        msg_valid;
  logic [3:0]  msg_type;
  logic [3:0]  msg_ch;
  logic [6:0]  msg_d0;
  logic [6:0]  msg_d1;
  logic        rt_valid;
  logic [7:0]  rt_byte;
  logic        sysex_active;
  logic        sysex_data_valid;
  logic [7:0]  sysex_len;
  logic        sysex_done;
  logic        as_timeout;

  int tests = 0;
  int fails = 0;

  always #5 sys_clk = ~sys_clk;

  midi_msg_parser #(
    .CH_MASK_W  (16),
    .SYSEX_LEN_W(8),
    .AS_TIMEOUT (100),
    .AS_CNT_W   (24)
  ) dut (
    .sys_clk         (sys_clk),
    .reset           (reset),
    .byte_in         (byte_in),
    .byte_valid      (byte_valid),
    .ch_mask         (ch_mask),
    .msg_valid       (msg_valid),
    .msg_type        (msg_type),
    .msg_ch          (msg_ch),
    .msg_d0          (msg_d0),
    .msg_d1          (msg_d1),
    .rt_valid        (rt_valid),
    .rt_byte         (rt_byte),
    .sysex_active    (sysex_active),
    .sysex_data_valid(sysex_data_valid),
    .sysex_len       (sysex_len),
    .sysex_done      (sysex_done),
    .as_timeout      (as_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte for one cycle; returns 1ns after the capturing edge.
  task automatic send(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic chk_msg(input string tag, input logic [3:0] t, input logic [3:0] c,
                         input logic [6:0] a, input logic [6:0] b);
    chk({tag, ".valid"}, 32'(msg_valid), 32'd1);
    chk({tag, ".type"}, 32'(msg_type), 32'(t));
    chk({tag, ".ch"}, 32'(msg_ch), 32'(c));
    chk({tag, ".d0"}, 32'(msg_d0), 32'(a));
    chk({tag, ".d1"}, 32'(msg_d1), 32'(b));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge sys_clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int pulses;
    int k;
    reset      = 1'b1;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    ch_mask    = 16'h0001;
    idle(3);
    reset = 1'b0;
    idle(1);
    chk("rst.msg_valid", 32'(msg_valid), 32'd0);
    chk("rst.msg_fields", {14'd0, msg_type, msg_ch, msg_d0, msg_d1}, 32'd0);
    chk("rst.rt", {23'd0, rt_valid, rt_byte}, 32'd0);
    chk("rst.sysex", {21'd0, sysex_active, sysex_data_valid, sysex_done, sysex_len}, 32'd0);
    chk("rst.as_timeout", 32'(as_timeout), 32'd0);

    // Basic note on, channel 0
    send(8'h90); chk("note.s", 32'(msg_valid), 32'd0);
    send(8'h3C); chk("note.d0", 32'(msg_valid), 32'd0);
    send(8'h64); chk_msg("note", 4'h9, 4'h0, 7'h3C, 7'h64);
    idle(1);
    chk("note.pulse_end", 32'(msg_valid), 32'd0);
    chk("note.hold_d1", 32'(msg_d1), 32'h64);

    // Running status on channel 3
    ch_mask = 16'h0008;
    send(8'h93); send(8'h40);
    send(8'h7F); chk_msg("rs1", 4'h9, 4'h3, 7'h40, 7'h7F);
    send(8'h41); chk("rs2.mid", 32'(msg_valid), 32'd0);
    send(8'h00); chk_msg("rs2", 4'h9, 4'h3, 7'h41, 7'h00);

    // Realtime interleave
    ch_mask = 16'h0001;
    send(8'h90);
    send(8'hF8);
    chk("rt1.valid", 32'(rt_valid), 32'd1);
    chk("rt1.byte", 32'(rt_byte), 32'hF8);
    chk("rt1.no_msg", 32'(msg_valid), 32'd0);
    send(8'h3C); chk("rt1.end", 32'(rt_valid), 32'd0);
    send(8'hFE);
    chk("rt2.valid", 32'(rt_valid), 32'd1);
    chk("rt2.byte", 32'(rt_byte), 32'hFE);
    send(8'h64); chk_msg("rtnote", 4'h9, 4'h0, 7'h3C, 7'h64);

    // SysEx short
    send(8'hF0);
    chk("sx.active", 32'(sysex_active), 32'd1);
    chk("sx.len0", 32'(sysex_len), 32'd0);
    pulses = 0;
    send(8'h7E); pulses += int'(sysex_data_valid);
    send(8'h01); pulses += int'(sysex_data_valid);
    send(8'h02); pulses += int'(sysex_data_valid);
    chk("sx.pulses", 32'(pulses), 32'd3);
    chk("sx.len3", 32'(sysex_len), 32'd3);
    chk("sx.done_early", 32'(sysex_done), 32'd0);
    send(8'hF7);
    chk("sx.done", 32'(sysex_done), 32'd1);
    chk("sx.inactive", 32'(sysex_active), 32'd0);
    chk("sx.len_hold", 32'(sysex_len), 32'd3);
    send(8'h40); chk("sx.after_idle", 32'(msg_valid), 32'd0);
    send(8'h40); chk("sx.after_idle2", 32'(msg_valid), 32'd0);

    // SysEx length saturation
    send(8'hF0);
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      send(8'(i & 8'h7F));
      pulses += int'(sysex_data_valid);
    end
    chk("sat.pulses", 32'(pulses), 32'd300);
    chk("sat.len", 32'(sysex_len), 32'd255);
    send(8'hF7); chk("sat.done", 32'(sysex_done), 32'd1);

    // Channel status terminates SysEx and starts a message
    send(8'hF0); send(8'h01);
    send(8'h90);
    chk("sxch.done", 32'(sysex_done), 32'd1);
    chk("sxch.inactive", 32'(sysex_active), 32'd0);
    send(8'h3C);
    send(8'h64); chk_msg("sxch", 4'h9, 4'h0, 7'h3C, 7'h64);

    // Masked channel, then system common
    ch_mask = 16'h0000;
    send(8'hB5); chk("mask.s", 32'(msg_valid), 32'd0);
    send(8'h07); chk("mask.d0", 32'(msg_valid), 32'd0);
    send(8'h40); chk("mask.d1", 32'(msg_valid), 32'd0);
    send(8'hF2); send(8'h10);
    send(8'h20); chk_msg("f2", 4'hF, 4'h2, 7'h10, 7'h20);
    send(8'h05); chk("f2.lone", 32'(msg_valid), 32'd0);
    send(8'h06); chk("f2.lone2", 32'(msg_valid), 32'd0);
    send(8'hF6); chk_msg("f6", 4'hF, 4'h6, 7'h00, 7'h00);
    send(8'hF1);
    send(8'h55); chk_msg("f1", 4'hF, 4'h1, 7'h55, 7'h00);

    // One-byte channel message with running status; mask sampled at completing byte
    send(8'hC3);
    ch_mask = 16'h0008;
    send(8'h12); chk_msg("pc1", 4'hC, 4'h3, 7'h12, 7'h00);
    send(8'h13); chk_msg("pc2", 4'hC, 4'h3, 7'h13, 7'h00);
    ch_mask = 16'h0000;
    send(8'h14); chk("pc3.masked", 32'(msg_valid), 32'd0);
    chk("pc3.hold_d0", 32'(msg_d0), 32'h13);

    // Reset mid-message and mid-SysEx
    ch_mask = 16'h0001;
    send(8'h90); send(8'h3C);
    pulse_reset();
    chk("rstmid.msg_fields", {14'd0, msg_type, msg_ch, msg_d0, msg_d1}, 32'd0);
    send(8'h64); chk("rstmid.no_msg", 32'(msg_valid), 32'd0);
    send(8'hF0); send(8'h01);
    pulse_reset();
    chk("rstsx.active", 32'(sysex_active), 32'd0);
    chk("rstsx.len", 32'(sysex_len), 32'd0);
    send(8'hF7); chk("rstsx.no_done", 32'(sysex_done), 32'd0);

`ifdef AS_TIMEOUT_EN
    send(8'hFE);
    chk("as.clear", 32'(as_timeout), 32'd0);
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      idle(1);
      if (as_timeout && k == 0) k = i;
    end
    chk("as.latency", 32'(k), 32'd100);
    send(8'hFE);
    chk("as.fe_clears", 32'(as_timeout), 32'd0);
    idle(49);
    send(8'h00);
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      idle(1);
      if (as_timeout && k == 0) k = i;
    end
    chk("as.delayed", 32'(k), 32'd100);
    send(8'hFE);
    idle(30);
    pulse_reset();
    chk("as.reset", 32'(as_timeout), 32'd0);
    idle(120);
    chk("as.disarmed", 32'(as_timeout), 32'd0);
`else
    send(8'hFE);
    idle(150);
    chk("as.tied0", 32'(as_timeout), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
